// File: rtl/regfile_pkg.sv
// Shared widths and types for the multi-port register file.
// Default widths match the parameter defaults of regfile_mp.
package regfile_pkg;

  localparam int REG_W = 8;
  localparam int REG_D = 4;

  typedef logic [REG_D-1:0] reg_addr_t;
  typedef logic [REG_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves which write port, if any, lands on one register address this cycle.
// The highest-index enabled port wins; writes to address 0 are dropped when ZERO_REG=1.
module regfile_wr_arb #(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [NW-1:0]   we,
  input  logic [NW*D-1:0] waddr,
  input  logic [NW*W-1:0] wdata,
  input  logic [D-1:0]    addr,
  output logic            hit,
  output logic [W-1:0]    data
);

  logic addr_dropped;
  assign addr_dropped = (ZERO_REG != 0) && (addr == '0);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Ascending scan: a later (higher-index) match overrides an earlier one.
    for (int k = 0; k < NW; k++) begin
      if (we[k] && (waddr[k*D +: D] == addr) && !addr_dropped) begin
        hit  = 1'b1;
        data = wdata[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero register, write-to-read bypass
// and a per-register pending-write scoreboard for load-use hazard stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int W        = REG_W,
  parameter int D        = REG_D,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic [NW-1:0]   RegWrite,
  input  logic [NW*D-1:0] writeReg,
  input  logic [NW*W-1:0] writeValue,
  input  logic [NR*D-1:0] srcReg,
  output logic [NR*W-1:0] ReadData,
  input  logic            Reserve,
  input  logic [D-1:0]    ReserveReg,
  output logic [NR-1:0]   Busy
);

  localparam int N = 1 << D;

  logic [W-1:0] regs_q [N];
  logic [W-1:0] regs_d [N];
  logic [N-1:0] pending_q, pending_d;

  logic [N-1:0] wr_hit;
  logic [W-1:0] wr_data [N];

  for (genvar n = 0; n < N; n++) begin : g_reg
    localparam logic [D-1:0] REG_ADDR = n;
    regfile_wr_arb #(.W(W), .D(D), .NW(NW), .ZERO_REG(ZERO_REG)) u_arb (
      .we    (RegWrite),
      .waddr (writeReg),
      .wdata (writeValue),
      .addr  (REG_ADDR),
      .hit   (wr_hit[n]),
      .data  (wr_data[n])
    );
  end

  always_comb begin
    for (int n = 0; n < N; n++) begin
      regs_d[n] = wr_hit[n] ? wr_data[n] : regs_q[n];
      // Reserve is applied after the clear so a same-cycle reserve wins.
      pending_d[n] = pending_q[n] & ~wr_hit[n];
      if (Reserve && (ReserveReg == D'(n)) && !((ZERO_REG != 0) && (n == 0))) begin
        pending_d[n] = 1'b1;
      end
    end
  end

  // NOTE: the storage array is reset along with the scoreboard so reads never see X.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int n = 0; n < N; n++) begin
        regs_q[n] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd
    logic [D-1:0] rd_addr;
    logic         rd_zero;
    logic         byp_hit;
    logic [W-1:0] byp_data;

    assign rd_addr = srcReg[r*D +: D];
    assign rd_zero = (ZERO_REG != 0) && (rd_addr == '0);

    regfile_wr_arb #(.W(W), .D(D), .NW(NW), .ZERO_REG(ZERO_REG)) u_byp (
      .we    (RegWrite),
      .waddr (writeReg),
      .wdata (writeValue),
      .addr  (rd_addr),
      .hit   (byp_hit),
      .data  (byp_data)
    );

    // Reset gating also blocks bypass of writes presented while in reset.
    assign ReadData[r*W +: W] = (!Reset_n || rd_zero)       ? '0       :
                                ((BYPASS != 0) && byp_hit)  ? byp_data :
                                                              regs_q[rd_addr];
    assign Busy[r] = Reset_n && !rd_zero && !((BYPASS != 0) && byp_hit) && pending_q[rd_addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed hazard/priority scenarios with
// literal expectations, then randomized traffic compared against an array model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int W  = REG_W;
  localparam int D  = REG_D;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int N  = 1 << D;

  logic            CLK = 1'b0;
  logic            Reset_n;
  logic [NW-1:0]   RegWrite;
  logic [NW*D-1:0] writeReg;
  logic [NW*W-1:0] writeValue;
  logic [NR*D-1:0] srcReg;
  logic [NR*W-1:0] ReadData;
  logic            Reserve;
  logic [D-1:0]    ReserveReg;
  logic [NR-1:0]   Busy;

  regfile_mp #(.W(W), .D(D), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1)) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .RegWrite   (RegWrite),
    .writeReg   (writeReg),
    .writeValue (writeValue),
    .srcReg     (srcReg),
    .ReadData   (ReadData),
    .Reserve    (Reserve),
    .ReserveReg (ReserveReg),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  reg_data_t mregs [N];
  bit        mpend [N];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Value a read port must show this cycle: zero reg, else newest same-cycle write, else storage.
  function automatic reg_data_t model_rd(input reg_addr_t a);
    reg_data_t v;
    if (!Reset_n || a == ZERO_ADDR) return '0;
    v = mregs[a];
    for (int k = 0; k < NW; k++)
      if (RegWrite[k] && writeReg[k*D +: D] == a) v = writeValue[k*W +: W];
    return v;
  endfunction

  function automatic bit model_busy(input reg_addr_t a);
    if (!Reset_n || a == ZERO_ADDR) return 1'b0;
    for (int k = 0; k < NW; k++)
      if (RegWrite[k] && writeReg[k*D +: D] == a) return 1'b0;
    return mpend[a];
  endfunction

  task automatic compare_outputs();
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("rd%0d", r), ReadData[r*W +: W], model_rd(srcReg[r*D +: D]));
      chk($sformatf("busy%0d", r), Busy[r], model_busy(srcReg[r*D +: D]));
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < N; n++) begin
      mregs[n] = '0;
      mpend[n] = 1'b0;
    end
  endtask

  task automatic set_rst(input bit v);
    Reset_n = v;
    if (!v) model_clear();
  endtask

  task automatic drive(input logic [1:0] we,
                       input reg_addr_t wa0, input reg_data_t wv0,
                       input reg_addr_t wa1, input reg_data_t wv1,
                       input reg_addr_t s0,  input reg_addr_t s1,
                       input logic res,      input reg_addr_t rr);
    RegWrite   = we;
    writeReg   = {wa1, wa0};
    writeValue = {wv1, wv0};
    srcReg     = {s1, s0};
    Reserve    = res;
    ReserveReg = rr;
    @(negedge CLK);
    compare_outputs();
  endtask

  task automatic tick();
    @(posedge CLK);
    if (Reset_n) begin
      for (int k = 0; k < NW; k++) begin
        if (RegWrite[k] && writeReg[k*D +: D] != ZERO_ADDR) begin
          mregs[writeReg[k*D +: D]] = writeValue[k*W +: W];
          mpend[writeReg[k*D +: D]] = 1'b0;
        end
      end
      if (Reserve && ReserveReg != ZERO_ADDR) mpend[ReserveReg] = 1'b1;
    end
    #1;
  endtask

  function automatic reg_addr_t rnd_addr();
    if ($urandom_range(0, 1) == 0) return reg_addr_t'($urandom_range(0, 7));
    return reg_addr_t'($urandom_range(0, N - 1));
  endfunction

  initial begin
    set_rst(1'b0);
    drive(2'b00, 0, 0, 0, 0, 3, 0, 1'b0, 0);
    chk("in_rst_rd", ReadData, 16'h0000);
    chk("in_rst_busy", Busy, 2'b00);
    tick();
    tick();
    set_rst(1'b1);

    // Write r3, confirm, then reset mid-run.
    drive(2'b01, 3, 8'h5A, 0, 8'h00, 0, 0, 1'b0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 3, 3, 1'b0, 0);
    chk("r3_written", ReadData[7:0], 8'h5A);
    set_rst(1'b0);
    drive(2'b00, 0, 0, 0, 0, 3, 3, 1'b0, 0);
    chk("r3_during_rst", ReadData[7:0], 8'h00);
    tick();
    set_rst(1'b1);
    for (int a = 0; a < N; a++) begin
      drive(2'b00, 0, 0, 0, 0, reg_addr_t'(a), reg_addr_t'(a), 1'b0, 0);
      chk("post_rst_rd", ReadData, 16'h0000);
      chk("post_rst_busy", Busy, 2'b00);
      tick();
    end

    // Dual write, distinct addresses.
    drive(2'b11, 1, 8'h11, 2, 8'h22, 0, 0, 1'b0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1, 2, 1'b0, 0);
    chk("dual_r1", ReadData[7:0], 8'h11);
    chk("dual_r2", ReadData[15:8], 8'h22);
    tick();

    // Same-address conflict: port 1 wins, also through bypass.
    drive(2'b11, 5, 8'hAA, 5, 8'hBB, 5, 5, 1'b0, 0);
    chk("conflict_bypass", ReadData[7:0], 8'hBB);
    tick();
    drive(2'b00, 0, 0, 0, 0, 5, 0, 1'b0, 0);
    chk("conflict_stored", ReadData[7:0], 8'hBB);
    tick();

    // Zero register ignores writes and reserves.
    drive(2'b01, 0, 8'hFF, 0, 8'h00, 0, 0, 1'b1, 0);
    chk("r0_bypass", ReadData[7:0], 8'h00);
    tick();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    chk("r0_rd", ReadData[7:0], 8'h00);
    chk("r0_busy", Busy[0], 1'b0);
    tick();

    // Scoreboard: reserve r7, then its result arrives.
    drive(2'b00, 0, 0, 0, 0, 7, 7, 1'b1, 7);
    chk("r7_busy_same_cycle", Busy[0], 1'b0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 7, 7, 1'b0, 0);
    chk("r7_busy", Busy[0], 1'b1);
    tick();
    drive(2'b01, 7, 8'h3C, 0, 8'h00, 7, 7, 1'b0, 0);
    chk("r7_busy_bypass", Busy[0], 1'b0);
    chk("r7_rd_bypass", ReadData[7:0], 8'h3C);
    tick();
    drive(2'b00, 0, 0, 0, 0, 7, 7, 1'b0, 0);
    chk("r7_busy_after", Busy[1], 1'b0);
    chk("r7_rd_after", ReadData[15:8], 8'h3C);
    tick();

    // Reserve and write r4 together: reserve wins.
    drive(2'b10, 0, 8'h00, 4, 8'h09, 4, 4, 1'b1, 4);
    tick();
    drive(2'b00, 0, 0, 0, 0, 4, 4, 1'b0, 0);
    chk("r4_rd", ReadData[7:0], 8'h09);
    chk("r4_busy", Busy[0], 1'b1);
    tick();
    drive(2'b01, 4, 8'h10, 0, 8'h00, 4, 4, 1'b0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 4, 4, 1'b0, 0);
    chk("r4_rd2", ReadData[7:0], 8'h10);
    chk("r4_busy2", Busy[0], 1'b0);
    tick();

    // Randomized traffic against the model, with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) set_rst(1'b0);
      else if (!Reset_n) set_rst(1'b1);
      drive(2'($urandom_range(0, 3)),
            rnd_addr(), reg_data_t'($urandom_range(0, 255)),
            rnd_addr(), reg_data_t'($urandom_range(0, 255)),
            rnd_addr(), rnd_addr(),
            1'($urandom_range(0, 2) == 0), rnd_addr());
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file with hardwired-zero register, write-to-read bypass and a per-register pending-write scoreboard.
- Sits between decode and execute. Reads feed ALU operands; write ports take ALU and load results.
- Scoreboard marks registers awaiting a multi-cycle result (load) so decode can stall on hazards.
- Async active-low reset clears all registers and scoreboard bits.

Parameters:
W, 8, data width in bits
D, 4, address width; 2**D registers
NR, 2, number of read ports (1..4)
NW, 2, number of write ports (1..2); higher index has priority
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reserves
BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
CLK  input  1  clock; all state updates on rising edge
Reset_n  input  1  asynchronous active-low reset
RegWrite  input  NW  per-port write enable
writeReg  input  NW*D  per-port write address; port k at [k*D +: D]
writeValue  input  NW*W  per-port write data; port k at [k*W +: W]
srcReg  input  NR*D  per-port read address; port r at [r*D +: D]
ReadData  output  NR*W  per-port read data, combinational
Reserve  input  1  mark ReserveReg pending
ReserveReg  input  D  register to mark pending
Busy  output  NR  per-read-port pending flag for srcReg, combinational

Behaviour:
- Reset (Reset_n=0, asynchronous): all 2**D registers <= 0; all pending bits <= 0. While in reset, ReadData reads 0 and Busy reads 0. Release is synchronous to the next CLK edge; the first write can occur on the first rising edge with Reset_n=1.
- Write: on posedge CLK, for each k with RegWrite[k]=1, registers[writeReg[k]] <= writeValue[k]. Writes with address 0 are dropped when ZERO_REG=1.
- Same-address multi-write in one cycle: the highest-index enabled port wins. Lower ports to that address are discarded.
- Read: ReadData[r] is combinational.
  - ZERO_REG=1 and srcReg[r]=0 → 0.
  - Otherwise, if BYPASS=1 and some enabled write port targets srcReg[r] with a nonzero address → that cycle's winning writeValue (same priority rule).
  - Otherwise → registers[srcReg[r]].
  - Read latency: 0 cycles. A written value is visible through storage on the cycle after the write, or in the same cycle via bypass.
- Scoreboard: one pending bit per register.
  - Reserve=1 sets pending[ReserveReg] on posedge; ignored for address 0 when ZERO_REG=1.
  - Any accepted write to register n clears pending[n] on posedge.
  - Reserve and write to the same register in the same cycle: reserve wins, so the bit ends set. This represents a new load issued behind an older result.
  - Reserve on an already-pending register: bit stays set, no error.
- Busy[r] = pending[srcReg[r]], masked to 0 for reg 0 when ZERO_REG=1. When BYPASS=1, also masked to 0 when a same-cycle accepted write targets srcReg[r], because the data is already forwarded.
- Mid-operation reset: pending writes and reserves in that cycle are lost; state is all zero after reset.
- Reading an address is always legal. No X propagates from storage, because reset initialises every entry.

Decomposition:
- Package regfile_pkg: typedefs reg_addr_t (logic [D-1:0]) and reg_data_t (logic [W-1:0]) for default D/W; constant ZERO_ADDR.
- One sub-module: regfile_wr_arb, a combinational per-address winning-write resolver, reused by storage update, bypass mux and scoreboard clear.
- Storage, scoreboard and read muxes live in regfile_mp.

Test Plan:
- Reset: hold Reset_n=0 mid-run after writing r3=0x5A, then release → r3 and all other registers read 0x00, Busy=0 for all.
- Dual write, distinct addresses: port0 r1=0x11, port1 r2=0x22 on one edge → next cycle srcReg0=1 reads 0x11, srcReg1=2 reads 0x22.
- Same-address conflict: port0 r5=0xAA and port1 r5=0xBB same edge → r5 reads 0xBB; with BYPASS=1, same-cycle read of r5 also shows 0xBB.
- Zero register: write r0=0xFF and Reserve r0 → r0 reads 0x00, Busy for r0 stays 0.
- Scoreboard: Reserve r7 → Busy(r7)=1 next cycle. Write r7=0x3C → Busy(r7)=0 in the same cycle (bypass) and after the edge, and r7 reads 0x3C.
- Reserve and write r4 in the same cycle with value 0x09 → r4=0x09 but Busy(r4)=1 afterwards. A subsequent write of 0x10 clears it.
